// File: rtl/mcnc_sync_counter_pkg.sv
// Shared types and helpers for the mcnc_sync_counter slice.
// Optional feature macro: MCNC_CNT_SATURATE_EN (saturate at terminal count).
package mcnc_cnt_pkg;

    typedef enum logic {
        CNT_UP   = 1'b0,
        CNT_DOWN = 1'b1
    } dir_e;

    // Terminal count for a given direction: top of range going up, zero going down.
    function automatic int unsigned tc_val(input dir_e dir, input int unsigned modulus);
        return (dir == CNT_UP) ? (modulus - 1) : 0;
    endfunction

endpackage

// File: rtl/mcnc_sync_counter_if.sv
// Control/status bundle for mcnc_sync_counter.
// master drives the controls and observes the count; slave is the counter.
interface mcnc_sync_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             clr_i;
    logic             load_i;
    logic [WIDTH-1:0] load_data_i;
    logic             enp_i;
    logic             ent_i;
    logic             dir_i;
    logic [WIDTH-1:0] q_o;
    logic             rco_o;
    logic             wrap_o;

    modport master (
        output clr_i, load_i, load_data_i, enp_i, ent_i, dir_i,
        input  q_o, rco_o, wrap_o
    );

    modport slave (
        input  clr_i, load_i, load_data_i, enp_i, ent_i, dir_i,
        output q_o, rco_o, wrap_o
    );
endinterface

// File: rtl/mcnc_sync_counter_next.sv
// Combinational next-state and terminal-count logic for mcnc_sync_counter.
// Optional feature macro: MCNC_CNT_SATURATE_EN (hold at terminal count).
module mcnc_cnt_next
    import mcnc_cnt_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 2 ** WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  dir_e             dir,
    input  logic             enp,
    input  logic             ent,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] next_q,
    output logic             wrap_next,
    output logic             tc
);

    // Compares are done one bit wider so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0]   ONE_W = (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] data_ext;
    logic [WIDTH:0] tc_w;

    // Priority clear > load > count > hold; wrap flagged only for a counted wrap.
    always_comb begin
        q_ext     = {1'b0, q};
        data_ext  = {1'b0, data};
        tc_w      = (WIDTH + 1)'(tc_val(dir, MODULUS));
        tc        = (q_ext == tc_w);
        next_q    = q;
        wrap_next = 1'b0;

        if (clr) begin
            next_q = '0;
        end else if (load) begin
            next_q = (data_ext < MOD_W) ? data : MAX_Q;
        end else if (enp && ent) begin
            if (tc) begin
`ifdef MCNC_CNT_SATURATE_EN
                next_q = q;
`else
                next_q    = (dir == CNT_UP) ? '0 : MAX_Q;
                wrap_next = 1'b1;
`endif
            end else if (dir == CNT_UP) begin
                next_q = WIDTH'(q_ext + ONE_W);
            end else begin
                next_q = WIDTH'(q_ext - ONE_W);
            end
        end
    end

endmodule

// File: rtl/mcnc_sync_counter.sv
// Parametrised synchronous load/count counter with cascadable ripple carry.
// Optional feature macro: MCNC_CNT_SATURATE_EN (saturate instead of wrap).
module mcnc_sync_counter
    import mcnc_cnt_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MODULUS   = 2 ** WIDTH,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    mcnc_sync_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic [WIDTH-1:0] next_q;
    logic             wrap_next;
    logic             tc;
    dir_e             dir;

    assign dir = dir_e'(bus.dir_i);

    mcnc_cnt_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q         (q_r),
        .dir       (dir),
        .enp       (bus.enp_i),
        .ent       (bus.ent_i),
        .clr       (bus.clr_i),
        .load      (bus.load_i),
        .data      (bus.load_data_i),
        .next_q    (next_q),
        .wrap_next (wrap_next),
        .tc        (tc)
    );

    // Count and wrap-pulse registers; reset aborts any pending wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r    <= RST_Q;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= next_q;
            wrap_r <= wrap_next;
        end
    end

    assign bus.q_o    = q_r;
    assign bus.wrap_o = wrap_r;
    assign bus.rco_o  = bus.ent_i & tc;

endmodule

// File: doc/mcnc_sync_counter.md
Name: mcnc_sync_counter

Overview:
- Parametrised synchronous counter slice, generalising the 4-bit load/count/carry combinational counter logic into a registered block.
- Adds parametric width and modulus, up/down direction, a registered wrap pulse and a cascadable ripple-carry output.
- Sits in the benchmark-derived datapath library as the sequential counter primitive. Instances chain through ent_i/rco_o to form wider counters.

Parameters:
- WIDTH, 4, counter bit width (≥1).
- MODULUS, 2**WIDTH, count range 0..MODULUS-1; 2 ≤ MODULUS ≤ 2**WIDTH.
- RESET_VAL, 0, value of q_o after reset; must be < MODULUS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr_i  input  1  synchronous clear to 0.
- load_i  input  1  synchronous parallel load.
- load_data_i  input  WIDTH  parallel load value.
- enp_i  input  1  count enable (parallel/local).
- ent_i  input  1  count enable (trickle/cascade); also gates rco_o.
- dir_i  input  1  0 = count up, 1 = count down.
- q_o  output  WIDTH  registered count.
- rco_o  output  1  combinational ripple carry/borrow out.
- wrap_o  output  1  registered one-cycle wrap pulse.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. While rst_n=0: q_o=RESET_VAL, wrap_o=0. Release is synchronous to clk and takes effect from the first rising edge with rst_n=1.
- Priority at each rising edge: clr_i > load_i > count > hold.
- clr_i=1: q_o←0, wrap_o←0.
- load_i=1 (clr_i=0):
  - q_o←load_data_i if load_data_i < MODULUS, otherwise q_o←MODULUS-1 (clamp).
  - wrap_o←0.
- Count when enp_i & ent_i and no clr_i/load_i:
  - Up: q_o←q_o+1, except q_o=MODULUS-1 → 0.
  - Down: q_o←q_o-1, except q_o=0 → MODULUS-1.
  - wrap_o←1 on the cycle following a wrap, otherwise 0.
- Hold otherwise: q_o unchanged, wrap_o←0.
- Terminal count TC: up: q_o==MODULUS-1; down: q_o==0.
- rco_o = ent_i & TC. Combinational from q_o, dir_i and ent_i; it does not depend on enp_i. Zero latency, so it can drive the next stage's ent_i.
- A dir_i change takes effect at the next count edge. rco_o follows dir_i immediately.
- Arithmetic is carried out in WIDTH+1 bits internally, so no overflow occurs before the modulus compare. Non-power-of-2 MODULUS is supported.
- Reset asserted mid-count aborts immediately; no wrap_o pulse is generated for the aborted count.
- Latency: q_o updates one cycle after the qualifying edge; wrap_o is aligned with the new q_o value.

Optional Feature:
- Macro: MCNC_CNT_SATURATE_EN.
- Defined:
  - At TC with count enabled, q_o holds at TC (no wrap) and wrap_o stays 0.
  - rco_o still asserts at TC.
  - Clear/load behave as normal.
- Undefined: modular wrap as specified above.

Decomposition:
- Shared package mcnc_cnt_pkg:
  - dir_e enum {CNT_UP=0, CNT_DOWN=1}.
  - Function tc_val(dir, modulus).
- Sub-module mcnc_cnt_next:
  - Purely combinational next-state and TC logic: inputs q, dir, enables, clr, load, data; outputs next_q, wrap_next, tc.
  - Top holds the registers and the reset.

Test Plan:
1. Reset/up count: WIDTH=4, MODULUS=16, RESET_VAL=0, rst_n low then release, enp=ent=1, dir=0 for 17 cycles.
   - q_o sequence 0..15,0.
   - rco_o=1 only while q_o=15.
   - wrap_o=1 exactly one cycle, coincident with q_o returning to 0.
2. Non-power-of-2 down count: MODULUS=10.
   - load 3, then dir=1 for 5 cycles → 2,1,0,9,8.
   - rco_o high at q_o=0; wrap_o pulses with q_o=9.
3. Priority and clamp: MODULUS=10.
   - clr_i=load_i=1 with data 7 → q_o=0.
   - load_i=1 with data 12 → q_o=9.
   - enp_i=1, ent_i=0 at q_o=9 up → holds at 9, rco_o=0.
4. Cascade: two instances, lower rco_o → upper ent_i, both enp=1, WIDTH=4.
   - After 256 counts from 0, the pair reads 0x00.
   - Upper increments only when lower=15.
   - Upper wrap_o pulses once.
5. Async reset mid-operation: assert rst_n low between edges while q_o=14 counting up.
   - q_o=RESET_VAL immediately, no clock needed.
   - wrap_o=0; no stale pulse after release.
6. MCNC_CNT_SATURATE_EN defined: count up from 13 for 5 cycles with MODULUS=16.
   - q_o 14,15,15,15,15.
   - wrap_o never asserts; rco_o stays 1 from q_o=15.
